// File: rtl/burst_shift_register_pkg.sv
// burst_shift_register_pkg: mode encodings and FSM state type shared by the burst shift register files
package burst_shift_register_pkg;
   localparam logic [1:0] MODE_SHL = 2'b00;
   localparam logic [1:0] MODE_SHR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;
   typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/burst_shift_register_shift_step.sv
// burst_shift_register_shift_step: one combinational shift/rotate step of q
//   in : q (current value), mode (operation), serial_in (fill bit for shifts)
//   out: q_next (value after the step), serial_out (bit leaving the register)
//   BURST_SHIFT_ARITH_EN: mode 01 replicates the sign bit instead of using serial_in
module burst_shift_register_shift_step
   import burst_shift_register_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [1:0]       mode,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q_next,
   output logic             serial_out
);
   logic lfill, rfill;
   assign lfill = mode == MODE_ROL ? q[WIDTH-1] : serial_in;
`ifdef BURST_SHIFT_ARITH_EN
   assign rfill = mode == MODE_ROR ? q[0] : mode == MODE_SHR ? q[WIDTH-1] : serial_in;
`else
   assign rfill = mode == MODE_ROR ? q[0] : serial_in;
`endif
   // mode bit 0 selects the right-moving operations
   assign q_next     = mode[0] ? {rfill, q[WIDTH-1:1]} : {q[WIDTH-2:0], lfill};
   assign serial_out = mode[0] ? q[0] : q[WIDTH-1];
endmodule

// File: rtl/burst_shift_register.sv
// burst_shift_register: WIDTH-bit register with parallel load and counted shift/rotate bursts
//   in : clk, reset (sync, active-high), load, data_in, start, mode, count, serial_in
//   out: q (contents), serial_out (last bit moved out), busy (burst running), done (one-cycle end pulse)
//   BURST_SHIFT_ARITH_EN: mode 01 becomes an arithmetic shift right
module burst_shift_register
   import burst_shift_register_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CW-1:0]    count,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);
   state_t           state;
   logic [1:0]       mode_r;
   logic [CW-1:0]    remaining;
   logic [WIDTH-1:0] q_next;
   logic             so_next;

   burst_shift_register_shift_step #(.WIDTH(WIDTH)) u_step (
      .q(q), .mode(mode_r), .serial_in(serial_in), .q_next(q_next), .serial_out(so_next)
   );

   assign busy = state == ST_BUSY;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         q          <= '0;
         serial_out <= 1'b0;
         done       <= 1'b0;
         mode_r     <= '0;
         remaining  <= '0;
      end else begin
         done <= 1'b0;
         if (state == ST_BUSY) begin
            q          <= q_next;
            serial_out <= so_next;
            remaining  <= remaining - 1'b1;
            if (remaining == CW'(1)) begin
               state <= ST_IDLE;
               done  <= 1'b1;
            end
         end else if (load) begin
            q <= data_in;
         end else if (start) begin
            if (count == '0) begin
               done <= 1'b1;
            end else begin
               mode_r    <= mode;
               remaining <= count;
               state     <= ST_BUSY;
            end
         end
      end
   end
endmodule

// File: tb/tb_burst_shift_register.sv
// tb_burst_shift_register: directed and random checks of burst_shift_register against a behavioural model
module tb_burst_shift_register;
   localparam int W  = 8;
   localparam int CW = $clog2(W+1);

   logic          clk, reset, load, start, serial_in;
   logic [W-1:0]  data_in, q;
   logic [1:0]    mode;
   logic [CW-1:0] count;
   logic          serial_out, busy, done;

   int errors = 0;
   int checks = 0;
   bit run = 0;

   burst_shift_register #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in), .start(start),
      .mode(mode), .count(count), .serial_in(serial_in),
      .q(q), .serial_out(serial_out), .busy(busy), .done(done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: a step counter plus plain shift arithmetic on an 8-bit value
   logic [W-1:0] mq;
   logic         mso, mdone, mbusy, fill;
   int           mrem;
   logic [1:0]   mmode;

   always @(posedge clk) begin
      if (reset) begin
         mq = '0; mso = 0; mdone = 0; mrem = 0; mmode = 0;
      end else begin
         mdone = 0;
         if (mrem > 0) begin
`ifdef BURST_SHIFT_ARITH_EN
            fill = mq[W-1];
`else
            fill = serial_in;
`endif
            case (mmode)
               2'd0: begin mso = mq[W-1]; mq = (mq << 1) | W'(serial_in); end
               2'd1: begin mso = mq[0]; mq = (mq >> 1) | (W'(fill) << (W-1)); end
               2'd2: begin mso = mq[W-1]; mq = (mq << 1) | (mq >> (W-1)); end
               default: begin mso = mq[0]; mq = (mq >> 1) | (mq << (W-1)); end
            endcase
            mrem--;
            if (mrem == 0) mdone = 1;
         end else if (load) begin
            mq = data_in;
         end else if (start) begin
            if (count == 0) mdone = 1;
            else begin mrem = int'(count); mmode = mode; end
         end
      end
      mbusy = mrem > 0;
   end

   always @(negedge clk) if (run) begin
      chk("q", 32'(q), 32'(mq));
      chk("serial_out", 32'(serial_out), 32'(mso));
      chk("busy", 32'(busy), 32'(mbusy));
      chk("done", 32'(done), 32'(mdone));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic l, input logic s, input logic [W-1:0] d,
                        input logic [1:0] m, input logic [CW-1:0] c, input logic si);
      load = l; start = s; data_in = d; mode = m; count = c; serial_in = si;
      tick(1);
      load = 0; start = 0;
   endtask

   initial begin
      reset = 1; load = 0; start = 0; data_in = 0; mode = 0; count = 0; serial_in = 0;
      tick(2);
      run = 1;
      chk("reset_q", 32'(q), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      reset = 0;
      // rotate left once
      drive(1, 0, 8'h81, 0, 0, 0);
      drive(0, 1, 0, 2'b10, 1, 0);
      chk("rol1_busy", 32'(busy), 1);
      chk("rol1_done_early", 32'(done), 0);
      tick(1);
      chk("rol1_q", 32'(q), 32'h03);
      chk("rol1_so", 32'(serial_out), 1);
      chk("rol1_done", 32'(done), 1);
      tick(1);
      chk("rol1_done_clear", 32'(done), 0);
      // shift left three with ones
      drive(1, 0, 8'h0F, 0, 0, 1);
      drive(0, 1, 0, 2'b00, 3, 1);
      tick(3);
      chk("shl3_q", 32'(q), 32'h7F);
      chk("shl3_done", 32'(done), 1);
      chk("shl3_busy", 32'(busy), 0);
      // shift right twice
      drive(1, 0, 8'h80, 0, 0, 0);
      drive(0, 1, 0, 2'b01, 2, 0);
      tick(2);
`ifdef BURST_SHIFT_ARITH_EN
      chk("shr2_q", 32'(q), 32'hE0);
`else
      chk("shr2_q", 32'(q), 32'h20);
`endif
      // load and start ignored mid-burst
      drive(1, 0, 8'hA5, 0, 0, 0);
      drive(0, 1, 0, 2'b10, 5, 0);
      tick(1);
      drive(1, 1, 8'hFF, 2'b00, 1, 1);
      tick(3);
      chk("rol5_q", 32'(q), 32'hB4);
      chk("rol5_done", 32'(done), 1);
      // reset aborts a running burst
      drive(0, 1, 0, 2'b00, 5, 1);
      tick(2);
      reset = 1;
      tick(1);
      reset = 0;
      chk("abort_q", 32'(q), 0);
      chk("abort_busy", 32'(busy), 0);
      tick(1);
      chk("abort_done", 32'(done), 0);
      // zero-count start and simultaneous load+start
      drive(1, 0, 8'h3C, 0, 0, 0);
      drive(0, 1, 0, 2'b00, 0, 1);
      chk("zero_q", 32'(q), 32'h3C);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_done", 32'(done), 1);
      tick(1);
      chk("zero_done_clear", 32'(done), 0);
      drive(1, 1, 8'h5A, 2'b00, 3, 1);
      chk("ldst_q", 32'(q), 32'h5A);
      chk("ldst_busy", 32'(busy), 0);
      // rotate right nine wraps
      drive(1, 0, 8'h01, 0, 0, 0);
      drive(0, 1, 0, 2'b11, 9, 0);
      tick(9);
      chk("ror9_q", 32'(q), 32'h80);
      chk("ror9_so", 32'(serial_out), 1);
      chk("ror9_done", 32'(done), 1);
      // random traffic checked every cycle by the compare process
      for (int i = 0; i < 600; i++) begin
         reset     = $urandom_range(0, 80) == 0;
         load      = $urandom_range(0, 5) == 0;
         start     = $urandom_range(0, 2) == 0;
         data_in   = W'($urandom);
         mode      = 2'($urandom);
         count     = CW'($urandom_range(0, (1 << CW) - 1));
         serial_in = 1'($urandom);
         tick(1);
      end
      reset = 0; load = 0; start = 0;
      tick(20);
      run = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
